// File: rtl/gnrc_sync_fifo_pkg.sv
// gnrc_sync_fifo shared helpers.
// Parameter sanity functions used at elaboration.
package gnrc_sync_fifo_pkg;

  function automatic bit is_pow2(int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit in_range(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/gnrc_simple_dpram.sv
// gnrc_simple_dpram: one write port, one read port.
// Registered read; output holds while ren_i is low.
module gnrc_simple_dpram #(
  parameter int DW           = 32,
  parameter int DP           = 512,
  parameter int DELAY        = 1,
  parameter int BYTE_WRITE   = 0,
  parameter int INIT_BY_ZERO = 0,
  parameter int AW           = $clog2(DP),
  parameter int MW           = (BYTE_WRITE != 0) ? (DW / 8) : 1
) (
  input  logic          clka_i,
  input  logic [AW-1:0] addra_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          wen_i,
  input  logic [MW-1:0] we_i,
  input  logic          clkb_i,
  input  logic [AW-1:0] addrb_i,
  input  logic          ren_i,
  output logic [DW-1:0] rdata_o
);

  localparam int BW = DW / MW;

  logic [DW-1:0] mem [DP];
  logic [DW-1:0] rdata_q;

  if (DELAY != 1) begin : g_bad_delay
    $error("gnrc_simple_dpram: only DELAY=1 is implemented");
  end
  if (INIT_BY_ZERO != 0) begin : g_bad_init
    $error("gnrc_simple_dpram: INIT_BY_ZERO is not implemented");
  end
  if ((BYTE_WRITE != 0) && ((DW % 8) != 0)) begin : g_bad_bw
    $error("gnrc_simple_dpram: BYTE_WRITE needs DW multiple of 8");
  end

  // Write port: lane-masked store.
  always_ff @(posedge clka_i) begin
    if (wen_i) begin
      for (int b = 0; b < MW; b++) begin
        if (we_i[b]) begin
          mem[addra_i][b*BW +: BW] <= wdata_i[b*BW +: BW];
        end
      end
    end
  end

  // Read port: register on enable, hold otherwise.
  always_ff @(posedge clkb_i) begin
    if (ren_i) begin
      rdata_q <= mem[addrb_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gnrc_sync_fifo.sv
// gnrc_sync_fifo: FWFT FIFO over a registered-read RAM.
// Head entry lives in the RAM output register.
module gnrc_sync_fifo
  import gnrc_sync_fifo_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DP       = 512,
  parameter int AF_LEVEL = DP - 1,
  parameter int AW       = $clog2(DP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wvalid_i,
  output logic          wready_o,
  input  logic [DW-1:0] wdata_i,
  output logic          rvalid_o,
  input  logic          rready_i,
  output logic [DW-1:0] rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          afull_o
);

  localparam int CW = AW + 1;
  localparam logic [AW:0] DP_C = CW'(DP);
  localparam logic [AW:0] AF_C = CW'(AF_LEVEL);

  if (!is_pow2(DP)) begin : g_bad_dp
    $error("gnrc_sync_fifo: DP must be a power of two >= 2");
  end
  if (!in_range(AF_LEVEL, 1, DP)) begin : g_bad_af
    $error("gnrc_sync_fifo: AF_LEVEL must be in 1..DP");
  end

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   ram_cnt;
  logic          rvalid_q;
  logic          push;
  logic          rd;

  assign count_o  = ram_cnt + CW'(rvalid_q);
  assign full_o   = (count_o == DP_C);
  assign empty_o  = (count_o == '0);
  assign afull_o  = (count_o >= AF_C);
  assign wready_o = !full_o && !rst_i;
  assign rvalid_o = rvalid_q;

  assign push = wvalid_i && wready_o;
  assign rd   = (ram_cnt != '0) && (!rvalid_q || rready_i);

  // Pointer, occupancy and head-valid tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1'b1);
      if (rd)   rptr <= rptr + AW'(1'b1);
      ram_cnt  <= ram_cnt + CW'(push) - CW'(rd);
      rvalid_q <= rd || (rvalid_q && !rready_i);
    end
  end

  gnrc_simple_dpram #(
    .DW           (DW),
    .DP           (DP),
    .DELAY        (1),
    .BYTE_WRITE   (0),
    .INIT_BY_ZERO (0)
  ) u_ram (
    .clka_i  (clk_i),
    .addra_i (wptr),
    .wdata_i (wdata_i),
    .wen_i   (push),
    .we_i    (1'b1),
    .clkb_i  (clk_i),
    .addrb_i (rptr),
    .ren_i   (rd),
    .rdata_o (rdata_o)
  );

endmodule

// File: tb/tb_gnrc_sync_fifo.sv
// Scoreboard bench for gnrc_sync_fifo (DW=8, DP=4).
// Directed stimulus; negedge monitor checks stream and flags.
module tb_gnrc_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          wvalid_i = 1'b0;
  logic          wready_o;
  logic [DW-1:0] wdata_i = '0;
  logic          rvalid_o;
  logic          rready_i = 1'b0;
  logic [DW-1:0] rdata_o;
  logic [2:0]    count_o;
  logic          full_o;
  logic          empty_o;
  logic          afull_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  bit            hold = 1'b0;
  logic [DW-1:0] hold_d;

  gnrc_sync_fifo #(
    .DW       (DW),
    .DP       (DP),
    .AF_LEVEL (3)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .wvalid_i (wvalid_i),
    .wready_o (wready_o),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .rdata_o  (rdata_o),
    .count_o  (count_o),
    .full_o   (full_o),
    .empty_o  (empty_o),
    .afull_o  (afull_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor and reference queue.
  always @(negedge clk) begin
    chk("wready", 32'(wready_o), 32'(!rst_i && (q.size() != DP)));
    if (rst_i) begin
      q.delete();
      hold = 1'b0;
    end else begin
      chk("count", 32'(count_o), 32'(q.size()));
      chk("empty", 32'(empty_o), 32'(q.size() == 0));
      chk("full", 32'(full_o), 32'(q.size() == DP));
      chk("afull", 32'(afull_o), 32'(q.size() >= 3));
      if (hold) begin
        chk("hold_valid", 32'(rvalid_o), 32'd1);
        chk("hold_data", 32'(rdata_o), 32'(hold_d));
      end
      if (rvalid_o === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head: rvalid with data %0h, expected none", rdata_o);
        end else begin
          chk("head", 32'(rdata_o), 32'(q[0]));
        end
      end
      if (flush_i) begin
        q.delete();
        hold = 1'b0;
      end else begin
        if (rvalid_o && rready_i && q.size() != 0) void'(q.pop_front());
        if (wvalid_i && (q.size() + ((rvalid_o && rready_i) ? 1 : 0)) < DP
            && count_o != 3'(DP))
          q.push_back(wdata_i);
        hold = rvalid_o && !rready_i;
        hold_d = rdata_o;
      end
    end
  end

  task automatic drain();
    bit done = 1'b0;
    rready_i = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (empty_o && !rvalid_o) done = 1'b1;
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_wready", 32'(wready_o), 32'd0);
    end
    rst_i = 1'b0;
    #1;
    chk("idle_wready", 32'(wready_o), 32'd1);
    chk("idle_empty", 32'(empty_o), 32'd1);
    chk("idle_rvalid", 32'(rvalid_o), 32'd0);
    chk("idle_count", 32'(count_o), 32'd0);

    // Single push, latency t+2
    rready_i = 1'b1;
    wvalid_i = 1'b1;
    wdata_i  = 8'h11;
    tick();
    wvalid_i = 1'b0;
    chk("lat_t1_rvalid", 32'(rvalid_o), 32'd0);
    tick();
    chk("lat_t2_rvalid", 32'(rvalid_o), 32'd1);
    chk("lat_t2_rdata", 32'(rdata_o), 32'h11);
    tick();
    chk("lat_t3_empty", 32'(empty_o), 32'd1);

    // Fill without popping
    rready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wvalid_i = 1'b1;
      wdata_i  = 8'hA0 + 8'(i);
      tick();
      chk("fill_afull", 32'(afull_o), 32'(i >= 2));
      chk("fill_full", 32'(full_o), 32'(i == 3));
    end
    chk("fill_count", 32'(count_o), 32'd4);
    chk("fill_wready", 32'(wready_o), 32'd0);
    wdata_i = 8'hA4;
    tick();
    chk("fifth_count", 32'(count_o), 32'd4);

    // Push and pop together at full
    wdata_i  = 8'hB0;
    rready_i = 1'b1;
    chk("fullpp_wready", 32'(wready_o), 32'd0);
    tick();
    wvalid_i = 1'b0;
    chk("fullpp_count", 32'(count_o), 32'd3);
    chk("fullpp_wready", 32'(wready_o), 32'd1);
    chk("fullpp_head", 32'(rdata_o), 32'hA1);
    drain();

    // Stall with pushes continuing
    rready_i = 1'b0;
    wvalid_i = 1'b1;
    wdata_i  = 8'h55;
    tick();
    wdata_i  = 8'h56;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", 32'(rvalid_o), 32'd1);
      chk("stall_rdata", 32'(rdata_o), 32'h55);
      wdata_i = 8'h57 + 8'(i);
      tick();
    end
    wvalid_i = 1'b0;
    chk("stall_count", 32'(count_o), 32'd4);
    drain();

    // Flush mid-stream
    rready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wvalid_i = 1'b1;
      wdata_i  = 8'hC0 + 8'(i);
      tick();
    end
    chk("pre_flush_count", 32'(count_o), 32'd3);
    wdata_i = 8'hC3;
    flush_i = 1'b1;
    tick();
    flush_i  = 1'b0;
    wvalid_i = 1'b0;
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_rvalid", 32'(rvalid_o), 32'd0);
    rready_i = 1'b1;
    wvalid_i = 1'b1;
    wdata_i  = 8'h77;
    tick();
    wvalid_i = 1'b0;
    tick();
    chk("post_flush_rvalid", 32'(rvalid_o), 32'd1);
    chk("post_flush_rdata", 32'(rdata_o), 32'h77);
    drain();

    tick();
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
